// File: rtl/timer_pkg.sv
// Shared widths, run-state encoding and per-digit modulus helpers for the BCD countdown timer.
package timer_pkg;

    localparam int unsigned DIGIT_W = 4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } run_state_t;

    // Modulus of digit idx: 6 when its bit is set in mask, else 10.
    function automatic int unsigned digit_mod(input int unsigned idx, input logic [31:0] mask);
        return (((mask >> idx) & 32'd1) != 32'd0) ? 32'd6 : 32'd10;
    endfunction

    // Saturate a digit value to modulus-1.
    function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] v,
                                                       input int unsigned modulus);
        logic [DIGIT_W-1:0] lim;
        lim = DIGIT_W'(modulus - 32'd1);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/bcd_countdown_timer_if.sv
// Keypad/control inputs and display/status outputs of the countdown timer.
interface bcd_countdown_timer_if
    import timer_pkg::*;
#(
    parameter int unsigned N_DIGITS = 4
);
    logic                          en;
    logic [DIGIT_W-1:0]            digit_in;
    logic                          digit_load;
    logic                          start;
    logic                          stop;
    logic                          clear_time;
    logic [DIGIT_W*N_DIGITS-1:0]   digits;
    logic                          zero;
    logic                          running;
    logic                          done;

    modport master (
        output en, digit_in, digit_load, start, stop, clear_time,
        input  digits, zero, running, done
    );

    modport slave (
        input  en, digit_in, digit_load, start, stop, clear_time,
        output digits, zero, running, done
    );
endinterface

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit with load, wrap to MOD-1 and borrow out.
module bcd_down_digit
    import timer_pkg::*;
#(
    parameter int unsigned MOD = 10
) (
    input  logic               clock,
    input  logic               clr,
    input  logic               ld,
    input  logic [DIGIT_W-1:0] ld_val,
    input  logic               dec,
    output logic [DIGIT_W-1:0] q,
    output logic               borrow_out,
    output logic               is_zero
);

    localparam logic [DIGIT_W-1:0] MAX_VAL = DIGIT_W'(MOD - 32'd1);

    // Digit register: load wins over decrement; 0 wraps to MAX_VAL.
    always_ff @(posedge clock or posedge clr) begin
        if (clr) begin
            q <= '0;
        end else if (ld) begin
            q <= ld_val;
        end else if (dec) begin
            q <= (q == '0) ? MAX_VAL : q - DIGIT_W'(1);
        end
    end

    assign is_zero    = (q == '0);
    assign borrow_out = dec && is_zero;

endmodule

// File: rtl/bcd_countdown_timer.sv
// Parametrised BCD countdown timer with keypad shift-in entry, start/stop and done pulse.
module bcd_countdown_timer
    import timer_pkg::*;
#(
    parameter int unsigned          N_DIGITS  = 4,
    parameter logic [N_DIGITS-1:0]  MOD6_MASK = 4'b0010
) (
    input  logic                   clock,
    input  logic                   clr,
    bcd_countdown_timer_if.slave   bus
);

    localparam int unsigned W = DIGIT_W * N_DIGITS;

    run_state_t         state_q, state_d;
    logic               done_q, done_d;
    logic               do_dec, cmd_clear, cmd_shift, terminal, ld;
    logic               zero, value_is_one;
    logic [DIGIT_W-1:0] q         [N_DIGITS];
    logic [DIGIT_W-1:0] ld_val    [N_DIGITS];
    logic [DIGIT_W-1:0] shift_val [N_DIGITS];
    logic [N_DIGITS-1:0] borrow, is_zero, dec_in;
    logic [W-1:0]       digits_flat;

    assign zero         = &is_zero;
    assign value_is_one = (q[0] == DIGIT_W'(1)) && (&is_zero[N_DIGITS-1:1]);
    assign terminal     = do_dec && value_is_one;
    // Top-digit borrow only occurs on a decrement from all-zero; force zero instead of wrapping.
    assign ld           = cmd_clear || cmd_shift || terminal || borrow[N_DIGITS-1];

    // Digit chain: borrow ripples upward, shift-in takes the next lower digit clamped to this modulus.
    for (genvar i = 0; i < N_DIGITS; i++) begin : g_digit
        localparam int unsigned MOD_I = digit_mod(i, 32'(MOD6_MASK));

        if (i == 0) begin : g_lsb
            assign dec_in[i]    = do_dec;
            assign shift_val[i] = clamp_digit(bus.digit_in, MOD_I);
        end else begin : g_upper
            assign dec_in[i]    = borrow[i-1];
            assign shift_val[i] = clamp_digit(q[i-1], MOD_I);
        end

        bcd_down_digit #(.MOD(MOD_I)) u_digit (
            .clock      (clock),
            .clr        (clr),
            .ld         (ld),
            .ld_val     (ld_val[i]),
            .dec        (dec_in[i]),
            .q          (q[i]),
            .borrow_out (borrow[i]),
            .is_zero    (is_zero[i])
        );

        assign digits_flat[DIGIT_W*i +: DIGIT_W] = q[i];
    end

    // Load value: shifted keypad entry, otherwise zero (clear / terminal count).
    always_comb begin
        for (int i = 0; i < N_DIGITS; i++) begin
            ld_val[i] = cmd_shift ? shift_val[i] : '0;
        end
    end

    // Run-state and done registers.
    always_ff @(posedge clock or posedge clr) begin
        if (clr) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    // Command decode with priority clear_time > stop > start > digit_load, then tick.
    always_comb begin
        state_d   = state_q;
        done_d    = 1'b0;
        do_dec    = 1'b0;
        cmd_clear = 1'b0;
        cmd_shift = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.clear_time) begin
                    cmd_clear = 1'b1;
                end else if (!bus.stop) begin
                    if (bus.start) begin
                        if (!zero) begin
                            state_d = ST_RUN;
                        end
                    end else if (bus.digit_load) begin
                        cmd_shift = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (bus.clear_time) begin
                    cmd_clear = 1'b1;
                    state_d   = ST_IDLE;
                end else if (bus.stop) begin
                    state_d = ST_IDLE;
                end else if (bus.en) begin
                    do_dec = 1'b1;
                    if (value_is_one) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.digits  = digits_flat;
    assign bus.zero    = zero;
    assign bus.running = (state_q == ST_RUN);
    assign bus.done    = done_q;

endmodule
